line_window_buffer: RTL and testbench

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

---
 rtl/line_window_buffer_pkg.sv | 10 +
 rtl/line_window_buffer_bram.sv | 22 ++
 rtl/line_window_buffer.sv | 127 ++++++++++++
 tb/tb_line_window_buffer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/line_window_buffer_pkg.sv
// Shared constants and types for the line window buffer.
package line_window_buffer_pkg;

  localparam int NR_MIN = 2;
  localparam int NR_MAX = 5;

  // Wide enough to hold any row age 0..NR_MAX-1
  typedef logic [$clog2(NR_MAX)-1:0] row_age_t;

endpackage

// File: rtl/line_window_buffer_bram.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle of latency.
module dualportBRAM #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_din;
    if (b_en) b_dout <= mem[b_addr];
  end

endmodule

// File: rtl/line_window_buffer.sv
// Vertical NR-row window over a raster pixel stream, one line store in BRAM.
// Optional top-edge replication when LWB_BORDER_REPLICATE_EN is defined.
module line_window_buffer
  import line_window_buffer_pkg::*;
#(
  parameter int XB       = 10,
  parameter int PB       = 8,
  parameter int NR       = 3,
  parameter int LINE_LEN = 640
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [PB-1:0]    i_data,
  output logic             o_valid,
  output logic [NR*PB-1:0] o_data,
  output logic [XB-1:0]    o_col,
  output logic             o_eol,
  output logic             o_primed
);

  localparam int            WW       = (NR-1)*PB;
  localparam logic [XB-1:0] COL_LAST = XB'(LINE_LEN-1);
  localparam row_age_t      ROW_TOP  = row_age_t'(NR-1);

  if (NR < NR_MIN || NR > NR_MAX) begin : g_nr_check
    $error("line_window_buffer: NR out of range");
  end

  function automatic row_age_t row_sat_inc(input row_age_t r);
    return (r == ROW_TOP) ? r : r + row_age_t'(1);
  endfunction

  logic [XB-1:0] col_cnt, col_cur;
  row_age_t      row_cnt, row_cur, row_nxt;
  logic          sof_hit;

  logic          vld_p0;
  logic [PB-1:0] pix_p0;
  logic [XB-1:0] col_p0;
  row_age_t      row_p0;
  logic [WW-1:0] rd_p0, wr_p0;
  logic [NR*PB-1:0] win_p0, tap_p0;
  logic          vld_out_p0;

  // A start-of-frame pixel is column 0 of row 0 regardless of counter state
  always_comb begin
    sof_hit = i_valid && i_sof;
    col_cur = sof_hit ? '0 : col_cnt;
    row_cur = sof_hit ? '0 : row_cnt;
    row_nxt = row_cnt;
    if (i_valid) row_nxt = (col_cur == COL_LAST) ? row_sat_inc(row_cur) : row_cur;
  end

  // Stage 0: counters, pixel capture, BRAM read at current column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      o_primed <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      if (i_valid) col_cnt <= (col_cur == COL_LAST) ? '0 : col_cur + XB'(1);
      row_cnt  <= row_nxt;
      o_primed <= (row_nxt == ROW_TOP);
      vld_p0   <= i_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (i_valid) begin
      pix_p0 <= i_data;
      col_p0 <= col_cur;
      row_p0 <= row_cur;
    end
  end

  dualportBRAM #(.AW(XB), .DW(WW)) u_bram (
    .clk    (clk),
    .a_we   (vld_p0),
    .a_addr (col_p0),
    .a_din  (wr_p0),
    .b_en   (i_valid),
    .b_addr (col_cur),
    .b_dout (rd_p0)
  );

  // Window is newest-first; dropping the oldest row gives the shifted store word
  assign win_p0 = {pix_p0, rd_p0};
  assign wr_p0  = win_p0[NR*PB-1 -: WW];

  always_comb begin
    tap_p0 = win_p0;
`ifdef LWB_BORDER_REPLICATE_EN
    begin : g_rep
      int src;
      src = 0;
      for (int k = 1; k < NR; k++) begin
        src = (k > int'(row_p0)) ? int'(row_p0) : k;
        tap_p0[(NR-k)*PB-1 -: PB] = win_p0[(NR-src)*PB-1 -: PB];
      end
    end
    vld_out_p0 = vld_p0 && (row_p0 <= ROW_TOP);
`else
    vld_out_p0 = vld_p0 && (row_p0 == ROW_TOP);
`endif
  end

  // Stage 1: BRAM write-back and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_col   <= '0;
      o_eol   <= 1'b0;
    end else begin
      o_valid <= vld_out_p0;
      o_eol   <= vld_out_p0 && (col_p0 == COL_LAST);
      if (vld_p0) begin
        o_data <= tap_p0;
        o_col  <= col_p0;
      end
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer (NR=3, PB=8, LINE_LEN=4).
module tb_line_window_buffer;

  localparam int XB = 10, PB = 8, NR = 3, LL = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_valid, i_sof;
  logic [PB-1:0]  i_data;
  logic           o_valid, o_eol, o_primed;
  logic [NR*PB-1:0] o_data;
  logic [XB-1:0]  o_col;

  line_window_buffer #(.XB(XB), .PB(PB), .NR(NR), .LINE_LEN(LL)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
    .o_valid(o_valid), .o_data(o_data), .o_col(o_col), .o_eol(o_eol), .o_primed(o_primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    int          col;
    logic        eol;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  int          cyc = 0;
  int          m_line, m_col;
  logic [7:0]  pix [0:63][0:LL-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_win(int l, int c);
    logic [23:0] w;
    int s;
    w = '0;
    for (int k = 0; k < 3; k++) begin
      s = (k > l) ? l : k;
      w[(3-k)*8-1 -: 8] = pix[l-s][c];
    end
    return w;
  endfunction

  function automatic bit expect_out(int l);
`ifdef LWB_BORDER_REPLICATE_EN
    return 1'b1;
`else
    return l >= 2;
`endif
  endfunction

  // One accepted pixel, then optional idle cycles
  task automatic drive(input logic [7:0] d, input logic sof, input int gap);
    exp_t e;
    if (sof) begin m_line = 0; m_col = 0; end
    pix[m_line][m_col] = d;
    if (expect_out(m_line)) begin
      e.data = exp_win(m_line, m_col);
      e.col  = m_col;
      e.eol  = (m_col == LL-1);
      e.cyc  = cyc;
      sb.push_back(e);
    end
    m_col++;
    if (m_col == LL) begin m_col = 0; m_line++; end
    i_valid = 1'b1; i_sof = sof; i_data = d;
    @(posedge clk); #1;
    i_valid = 1'b0; i_sof = 1'b0;
    check("primed", 32'(o_primed), 32'(m_line >= 2));
    for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},  32'(o_valid),  0);
    check({tag, "_data"},   32'(o_data),   0);
    check({tag, "_col"},    32'(o_col),    0);
    check({tag, "_eol"},    32'(o_eol),    0);
    check({tag, "_primed"}, 32'(o_primed), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data", 32'(o_data), 32'(e.data));
        check("col",  32'(o_col),  32'(e.col));
        check("eol",  32'(o_eol),  32'(e.eol));
        check("latency", 32'(cyc - e.cyc), 2);
      end
    end else if (rst_n === 1'b1) begin
      check("eol_idle", 32'(o_eol), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_data = '0;
    m_line = 0; m_col = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back stream with start of frame on the first pixel
    for (int p = 0; p < 12; p++) drive(8'(p), p == 0, 0);
    drain("drain_a");

    // Same stream, one idle cycle between pixels
    for (int p = 0; p < 12; p++) drive(8'(p), p == 0, 1);
    drain("drain_b");

    // Start of frame reasserted mid-line at pixel 9
    for (int p = 0; p < 21; p++) drive(8'(p), p == 0 || p == 9, 0);
    drain("drain_c");

    // Primed stream continues, reset pulsed after its seventh pixel
    for (int p = 21; p < 28; p++) drive(8'(p), 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    sb.delete();
    m_line = 0; m_col = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int p = 0; p < 12; p++) drive(8'(8'h40 + p), 1'b0, 0);
    drain("drain_d");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
